// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding and default sizing for the sort engine
package sort_pkg;
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
endpackage

// File: rtl/compare_swap.sv
// compare_swap: orders one element pair, swapping only on strict inequality
module compare_swap #(
  parameter int WIDTH = 8,
  parameter bit DESCENDING = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  logic swap;
  assign swap = DESCENDING ? (a < b) : (a > b);
  assign x = swap ? b : a;
  assign y = swap ? a : b;
endmodule

// File: rtl/sort_engine.sv
// sort_engine: loads a frame, odd-even transposition sorts it, then streams it out
module sort_engine
  import sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter bit DESCENDING = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  state_t state;
  logic [CW-1:0] count, pass, index;
  logic [WIDTH-1:0] elem [DEPTH];
  logic [WIDTH-1:0] nxt [DEPTH];
  logic [WIDTH-1:0] left [DEPTH-1];
  logic [WIDTH-1:0] right [DEPTH-1];
  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_cs
    compare_swap #(.WIDTH(WIDTH), .DESCENDING(DESCENDING)) u_cs (
      .a(elem[i]),
      .b(elem[i+1]),
      .x(left[i]),
      .y(right[i])
    );
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_nxt
    if (i == 0) begin : g_first
      assign nxt[i] = pass[0] ? elem[i] : left[i];
    end else if (i % 2 == 0) begin : g_even
      assign nxt[i] = pass[0] ? right[i-1] : left[i];
    end else if (i == DEPTH - 1) begin : g_top
      assign nxt[i] = pass[0] ? elem[i] : right[i-1];
    end else begin : g_odd
      assign nxt[i] = pass[0] ? left[i] : right[i-1];
    end
  end
  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy      = state != LOAD;
  assign out_last  = (state == DRAIN) && (index == LAST);
  assign out_data  = elem[index];
  // frame sequencer: load elements, run DEPTH transposition passes, drain in order
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      count <= '0;
      pass  <= '0;
      index <= '0;
      for (int k = 0; k < DEPTH; k++) elem[k] <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          elem[count] <= in_data;
          count <= (count == LAST) ? '0 : count + 1'b1;
          if (count == LAST) begin
            state <= SORT;
            pass  <= '0;
          end
        end
        SORT: begin
          for (int k = 0; k < DEPTH; k++) elem[k] <= nxt[k];
          pass <= (pass == LAST) ? '0 : pass + 1'b1;
          if (pass == LAST) begin
            state <= DRAIN;
            index <= '0;
          end
        end
        DRAIN: if (out_ready) begin
          index <= (index == LAST) ? '0 : index + 1'b1;
          if (index == LAST) begin
            state <= LOAD;
            count <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: directed vector bench for descending, ascending and 16-bit engines
module tb_sort_engine;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic dr_in_ready, dr_out_valid, dr_out_last, dr_busy;
  logic [7:0] dr_out_data;
  logic ar_in_ready, ar_out_valid, ar_out_last, ar_busy;
  logic [7:0] ar_out_data;
  logic w_in_valid = 0, w_out_ready = 0;
  logic [15:0] w_in_data = 0;
  logic w_in_ready, w_out_valid, w_out_last, w_busy;
  logic [15:0] w_out_data;
  int total = 0, bad = 0;

  sort_engine dut_dsc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(dr_in_ready),
    .out_valid(dr_out_valid), .out_data(dr_out_data), .out_last(dr_out_last),
    .out_ready(out_ready), .busy(dr_busy));
  sort_engine #(.DESCENDING(1'b0)) dut_asc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(ar_in_ready),
    .out_valid(ar_out_valid), .out_data(ar_out_data), .out_last(ar_out_last),
    .out_ready(out_ready), .busy(ar_busy));
  sort_engine #(.WIDTH(16), .DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_data(w_in_data), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_last(w_out_last),
    .out_ready(w_out_ready), .busy(w_busy));

  typedef struct {
    logic [7:0] din [8];
    logic [7:0] dsc [8];
    logic [7:0] asc [8];
  } vec_t;
  vec_t vt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load8(input int v, input int gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 3 && gap > 0) begin
        in_valid = 0;
        repeat (gap) @(posedge clk);
        #1;
        chk("partial_ready", {31'd0, dr_in_ready}, 1);
        chk("partial_valid", {31'd0, dr_out_valid}, 0);
      end
      in_valid = 1;
      in_data = vt[v].din[i];
      chk("load_ready", {31'd0, dr_in_ready & ar_in_ready}, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_data = 8'hEE;
  endtask

  task automatic wait_out(input int lat);
    int n = 0;
    while (!dr_out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 0;
    chk("latency", n, lat);
    chk("asc_valid", {31'd0, ar_out_valid}, 1);
  endtask

  task automatic drain(input int v, input bit stall);
    for (int k = 0; k < 8; k++) begin
      chk("dsc_data", {24'd0, dr_out_data}, {24'd0, vt[v].dsc[k]});
      chk("asc_data", {24'd0, ar_out_data}, {24'd0, vt[v].asc[k]});
      chk("dsc_last", {31'd0, dr_out_last}, {31'd0, k == 7});
      chk("asc_last", {31'd0, ar_out_last}, {31'd0, k == 7});
      chk("drain_ready", {31'd0, dr_in_ready}, 0);
      chk("drain_busy", {31'd0, dr_busy}, 1);
      if (stall && k % 2 == 0) begin
        out_ready = 0;
        repeat (2) begin
          @(posedge clk);
          #1;
          chk("hold_data", {24'd0, dr_out_data}, {24'd0, vt[v].dsc[k]});
          chk("hold_last", {31'd0, dr_out_last}, {31'd0, k == 7});
          chk("hold_ready", {31'd0, dr_in_ready}, 0);
        end
      end
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
    end
    chk("ready_back", {31'd0, dr_in_ready & ar_in_ready}, 1);
    chk("valid_off", {31'd0, dr_out_valid | ar_out_valid}, 0);
    chk("busy_off", {31'd0, dr_busy | ar_busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] wi [4];
    logic [15:0] we [4];
    int n;
    vt[0].din = '{28, 250, 3, 250, 0, 255, 17, 100};
    vt[0].dsc = '{255, 250, 250, 100, 28, 17, 3, 0};
    vt[0].asc = '{0, 3, 17, 28, 100, 250, 250, 255};
    vt[1].din = '{7, 6, 5, 4, 3, 2, 1, 0};
    vt[1].dsc = '{7, 6, 5, 4, 3, 2, 1, 0};
    vt[1].asc = '{0, 1, 2, 3, 4, 5, 6, 7};
    vt[2].din = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    vt[2].dsc = vt[2].din;
    vt[2].asc = vt[2].din;
    vt[3].din = '{1, 2, 3, 4, 5, 6, 7, 8};
    vt[3].dsc = '{8, 7, 6, 5, 4, 3, 2, 1};
    vt[3].asc = '{1, 2, 3, 4, 5, 6, 7, 8};
    wi = '{16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF};
    we = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, dr_in_ready & ar_in_ready & w_in_ready}, 1);
    chk("rst_out_valid", {31'd0, dr_out_valid | ar_out_valid | w_out_valid}, 0);
    chk("rst_out_last", {31'd0, dr_out_last | ar_out_last | w_out_last}, 0);
    chk("rst_busy", {31'd0, dr_busy | ar_busy | w_busy}, 0);
    rst_n = 1;
    for (int v = 0; v < 4; v++) begin
      load8(v, v == 3 ? 20 : 0);
      wait_out(8);
      drain(v, v % 2 == 1);
    end
    load8(0, 0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 0;
    chk("mid_sort_busy", {31'd0, dr_busy}, 1);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("abort_ready", {31'd0, dr_in_ready & ar_in_ready}, 1);
    chk("abort_busy", {31'd0, dr_busy | ar_busy}, 0);
    for (int c = 0; c < 12; c++) begin
      chk("abort_no_out", {31'd0, dr_out_valid | ar_out_valid}, 0);
      @(posedge clk);
      #1;
    end
    load8(3, 0);
    wait_out(8);
    drain(3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      w_in_valid = 1;
      w_in_data = wi[i];
      @(posedge clk);
      #1;
    end
    w_in_valid = 0;
    n = 0;
    while (!w_out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w_latency", n, 4);
    for (int k = 0; k < 4; k++) begin
      chk("w_data", {16'd0, w_out_data}, {16'd0, we[k]});
      chk("w_last", {31'd0, w_out_last}, {31'd0, k == 3});
      w_out_ready = 1;
      @(posedge clk);
      #1;
      w_out_ready = 0;
    end
    chk("w_ready_back", {31'd0, w_in_ready}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sort_engine.md
SORT_ENGINE -- requirements
Module: sort_engine

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data element.
REQ-002 Parameter DEPTH, default 8: elements per frame; SHALL be even and at least 2.
REQ-003 Parameter DESCENDING, default 1: 1 = largest value first; 0 = smallest value first.
REQ-004 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  producer presents an element on in_data.
REQ-007 in_data  input  WIDTH  unsigned element to load.
REQ-008 in_ready  output  1  engine can accept an element this cycle.
REQ-009 out_valid  output  1  out_data holds a sorted element.
REQ-010 out_data  output  WIDTH  current sorted element.
REQ-011 out_last  output  1  marks the final element of the frame.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 busy  output  1  high whenever the state is not LOAD.

Function
REQ-014 The engine SHALL use three states: LOAD, SORT and DRAIN.
REQ-015 Power-up state SHALL be LOAD, with load count = 0.
REQ-016 In LOAD, in_ready = 1 and out_valid = 0.
REQ-017 In LOAD, each cycle with in_valid && in_ready SHALL write in_data to element[count] and increment count.
REQ-018 On the handshake that writes element[DEPTH-1], the next state SHALL be SORT, pass counter = 0 and in_ready = 0.
REQ-019 SORT SHALL perform odd-even transposition, one pass per cycle, for exactly DEPTH cycles.
REQ-020 An even pass SHALL compare pairs (0,1),(2,3),...; an odd pass SHALL compare pairs (1,2),(3,4),...
REQ-021 The first pass SHALL be even, and passes SHALL alternate.
REQ-022 For each compared pair (i,i+1) with DESCENDING=1, the two elements SHALL swap when element[i] < element[i+1].
REQ-023 For each compared pair (i,i+1) with DESCENDING=0, the two elements SHALL swap when element[i] > element[i+1].
REQ-024 Equal elements SHALL NOT be swapped.
REQ-025 Comparison SHALL be unsigned at full WIDTH, with no truncation.
REQ-026 After the pass with counter = DEPTH-1, the next state SHALL be DRAIN, with index = 0.
REQ-027 In DRAIN, out_valid = 1 and out_data = element[index].
REQ-028 In DRAIN, out_last = 1 exactly when index = DEPTH-1.
REQ-029 Latency: out_valid SHALL first assert exactly DEPTH cycles after the cycle that accepted the final input element.
REQ-030 In DRAIN, out_ready = 1 SHALL increment index; out_ready = 0 SHALL hold out_data and out_last stable.
REQ-031 Acceptance of the element with out_last = 1 SHALL return the state to LOAD with count = 0.
REQ-032 in_ready SHALL rise in the cycle after that acceptance; there is no overlap between DRAIN and LOAD.
REQ-033 in_valid SHALL be ignored outside LOAD.
REQ-034 out_ready SHALL be ignored outside DRAIN.
REQ-035 A partial frame (count < DEPTH) SHALL wait in LOAD indefinitely; no timeout and no flush.

Reset
REQ-036 When rst_n = 0 at a rising edge: state = LOAD, count = 0, pass = 0, index = 0.
REQ-037 During reset, in_ready = 1 from the first post-reset cycle, and out_valid = 0, out_last = 0, busy = 0.
REQ-038 Element storage SHALL be cleared to 0.
REQ-039 Reset SHALL abort any LOAD, SORT or DRAIN in progress with no output of partial results.

Structure
REQ-040 Package sort_pkg SHALL hold the state enum typedef (LOAD, SORT, DRAIN).
REQ-041 Package sort_pkg SHALL hold the default WIDTH and DEPTH constants.
REQ-042 Sub-module compare_swap SHALL be parameterised by WIDTH and DESCENDING.
REQ-043 compare_swap SHALL be purely combinational: two inputs in, two outputs out, ordered per REQ-022 to REQ-024.
REQ-044 sort_engine SHALL instantiate DEPTH-1 compare_swap cells, selected per pass by the parity of the pass counter.
REQ-045 Counters SHALL be sized with clog2 of DEPTH.

Verification
REQ-046 Default parameters; load 28,250,3,250,0,255,17,100 with no stalls -> out_valid rises exactly 8 cycles after the last accepted input; outputs are 255,250,250,100,28,17,3,0 with out_last on 0.
REQ-047 DESCENDING=0, same input -> outputs are 0,3,17,28,100,250,250,255.
REQ-048 Already-sorted descending input 7,6,5,4,3,2,1,0 -> output unchanged; all-equal 0xAA ×8 -> eight outputs of 0xAA.
REQ-049 Drain with out_ready toggling 1,0,0,1,... -> each element held stable while stalled; no element lost or duplicated; in_ready = 0 until the cycle after out_last is accepted.
REQ-050 Assert rst_n = 0 for one cycle mid-SORT, then load a new frame -> no outputs from the aborted frame; the new frame sorts correctly.
REQ-051 WIDTH=16, DEPTH=4, input 0xFFFF,0x0001,0x8000,0x7FFF -> outputs are 0xFFFF,0x8000,0x7FFF,0x0001; latency is 4 cycles.
